// File: rtl/maze_mapper_pipe.sv
// -----------------------------------------------------------------------------
// maze_mapper_pipe
//   Holds a MAZE_X x MAZE_Y tile map that the update receiver writes over a
//   valid/ready port. The map is rendered to VGA through a 2-stage registered
//   pixel pipeline. After reset every tile is swept to zero. The tile that
//   was previously marked "current" loses its current bit automatically.
//   Updates with out-of-range coordinates are dropped and counted.
//
// Ports
//   CLK        system / pixel clock
//   RESET_N    synchronous active-low reset
//   DATA_IN    update word {x, y, payload[10:0]}
//   DATA_VAL   update valid
//   DATA_RDY   update ready; a transfer happens when DATA_VAL && DATA_RDY
//   PIXEL_X    current pixel column
//   PIXEL_Y    current pixel row
//   COLOR_OUT  RGB332 pixel, two cycles after PIXEL_X/PIXEL_Y
//   DONE       sticky done flag
//   ERR_CNT    saturating count of rejected updates
// -----------------------------------------------------------------------------
module maze_mapper_pipe #(
    parameter int MAZE_X    = 4,
    parameter int MAZE_Y    = 5,
    parameter int X_BITS    = 2,
    parameter int Y_BITS    = 3,
    parameter int TILE_SIZE = 70,
    parameter int WALL_PX   = 3,
    parameter int IR_BUF    = 20,
    parameter int FLIP_Y    = 1,
    parameter int BANNER_X0 = 500,
    parameter int BANNER_X1 = 550
) (
    input  logic                       CLK,
    input  logic                       RESET_N,
    input  logic [X_BITS+Y_BITS+10:0]  DATA_IN,
    input  logic                       DATA_VAL,
    output logic                       DATA_RDY,
    input  logic [9:0]                 PIXEL_X,
    input  logic [9:0]                 PIXEL_Y,
    output logic [7:0]                 COLOR_OUT,
    output logic                       DONE,
    output logic [7:0]                 ERR_CNT
);
    localparam int N_TILES = MAZE_X * MAZE_Y;
    localparam int ADDR_W  = (N_TILES > 1) ? $clog2(N_TILES) : 1;

    localparam logic [1:0] S_INIT = 2'd0;
    localparam logic [1:0] S_IDLE = 2'd1;
    localparam logic [1:0] S_CLR  = 2'd2;

    function automatic logic [ADDR_W-1:0] tile_addr(input int x, input int y);
        int a;
        a = y * MAZE_X + x;
        return a[ADDR_W-1:0];
    endfunction

    // ---------------------------------------------------------------- update FSM
    logic [10:0]        mem_q [N_TILES];
    logic [1:0]         state_q, state_d;
    logic [ADDR_W-1:0]  sweep_q, sweep_d;
    logic               cur_valid_q, cur_valid_d;
    logic [X_BITS-1:0]  cur_x_q, cur_x_d, old_x_q, old_x_d;
    logic [Y_BITS-1:0]  cur_y_q, cur_y_d, old_y_q, old_y_d;
    logic               done_q, done_d;
    logic [7:0]         err_q, err_d;

    logic               mem_we;
    logic [ADDR_W-1:0]  mem_waddr;
    logic [10:0]        mem_wdata;

    logic [X_BITS-1:0]  upd_x;
    logic [Y_BITS-1:0]  upd_y;
    logic [10:0]        payload;
    logic               xfer, in_range, same_as_cur;
    logic [ADDR_W-1:0]  old_addr;

    assign upd_x       = DATA_IN[X_BITS+Y_BITS+10 -: X_BITS];
    assign upd_y       = DATA_IN[Y_BITS+10 -: Y_BITS];
    assign payload     = DATA_IN[10:0];
    assign DATA_RDY    = (state_q == S_IDLE);
    assign xfer        = DATA_VAL && DATA_RDY;
    // Compare at integer width so the check survives a field wider than the map.
    assign in_range    = (int'(upd_x) < MAZE_X) && (int'(upd_y) < MAZE_Y);
    assign same_as_cur = (upd_x == cur_x_q) && (upd_y == cur_y_q);
    assign old_addr    = tile_addr(int'(old_x_q), int'(old_y_q));

    always_comb begin
        // NOTE: every signal gets a default first so no path leaves it unassigned (no latch).
        state_d     = state_q;
        sweep_d     = sweep_q;
        cur_valid_d = cur_valid_q;
        cur_x_d     = cur_x_q;
        cur_y_d     = cur_y_q;
        old_x_d     = old_x_q;
        old_y_d     = old_y_q;
        done_d      = done_q;
        err_d       = err_q;
        mem_we      = 1'b0;
        mem_waddr   = '0;
        mem_wdata   = '0;

        case (state_q)
            S_INIT: begin
                mem_we    = 1'b1;
                mem_waddr = sweep_q;
                if (sweep_q == ADDR_W'(N_TILES - 1)) begin
                    state_d = S_IDLE;
                    sweep_d = '0;
                end else begin
                    sweep_d = sweep_q + 1'b1;
                end
            end
            S_IDLE: begin
                if (xfer) begin
                    if (!in_range) begin
                        if (err_q != 8'hFF) err_d = err_q + 8'd1;
                    end else begin
                        mem_we    = 1'b1;
                        mem_waddr = tile_addr(int'(upd_x), int'(upd_y));
                        mem_wdata = payload;
                        if (payload[0]) done_d = 1'b1;
                        if (payload[1]) begin
                            // A new current tile elsewhere: strip the old tile's flag next cycle.
                            if (cur_valid_q && !same_as_cur) begin
                                old_x_d = cur_x_q;
                                old_y_d = cur_y_q;
                                state_d = S_CLR;
                            end
                            cur_x_d     = upd_x;
                            cur_y_d     = upd_y;
                            cur_valid_d = 1'b1;
                        end else if (same_as_cur) begin
                            cur_valid_d = 1'b0;
                        end
                    end
                end
            end
            S_CLR: begin
                mem_we    = 1'b1;
                mem_waddr = old_addr;
                mem_wdata = mem_q[old_addr] & ~11'h002;
                state_d   = S_IDLE;
            end
            default: state_d = S_INIT;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge CLK) begin
        if (!RESET_N) begin
            state_q     <= S_INIT;
            sweep_q     <= '0;
            cur_valid_q <= 1'b0;
            cur_x_q     <= '0;
            cur_y_q     <= '0;
            old_x_q     <= '0;
            old_y_q     <= '0;
            done_q      <= 1'b0;
            err_q       <= 8'd0;
        end else begin
            state_q     <= state_d;
            sweep_q     <= sweep_d;
            cur_valid_q <= cur_valid_d;
            cur_x_q     <= cur_x_d;
            cur_y_q     <= cur_y_d;
            old_x_q     <= old_x_d;
            old_y_q     <= old_y_d;
            done_q      <= done_d;
            err_q       <= err_d;
        end
    end

    // NOTE: the tile memory has no reset; the INIT sweep zeroes it instead.
    always_ff @(posedge CLK) begin
        if (mem_we) mem_q[mem_waddr] <= mem_wdata;
    end

    assign DONE    = done_q;
    assign ERR_CNT = err_q;

    // ---------------------------------------------------------- render stage 1
    logic [9:0] py, tx_c, ty_c;
    logic [9:0] s1_tx_q, s1_ty_q, s1_ox_q, s1_oy_q;
    logic       s1_in_maze_q, s1_banner_q;

    assign py   = (FLIP_Y != 0) ? (10'd479 - PIXEL_Y) : PIXEL_Y;
    assign tx_c = PIXEL_X / 10'(TILE_SIZE);
    assign ty_c = py / 10'(TILE_SIZE);

    always_ff @(posedge CLK) begin
        if (!RESET_N) begin
            s1_tx_q      <= '0;
            s1_ty_q      <= '0;
            s1_ox_q      <= '0;
            s1_oy_q      <= '0;
            s1_in_maze_q <= 1'b0;
            s1_banner_q  <= 1'b0;
        end else begin
            s1_tx_q      <= tx_c;
            s1_ty_q      <= ty_c;
            s1_ox_q      <= PIXEL_X - tx_c * 10'(TILE_SIZE);
            s1_oy_q      <= py - ty_c * 10'(TILE_SIZE);
            s1_in_maze_q <= (int'(PIXEL_X) < MAZE_X * TILE_SIZE) && (int'(py) < MAZE_Y * TILE_SIZE);
            s1_banner_q  <= (int'(PIXEL_X) >= BANNER_X0) && (int'(PIXEL_X) <= BANNER_X1);
        end
    end

    // ---------------------------------------------------------- render stage 2
    logic [ADDR_W-1:0] rd_addr;
    logic [10:0]       rd_word;
    logic [7:0]        color_d, color_q;
    logic              unused_rd_bits;

    // Out-of-maze pixels may carry tile indices past the map; park them on tile 0.
    assign rd_addr        = s1_in_maze_q ? tile_addr(int'(s1_tx_q), int'(s1_ty_q)) : '0;
    assign rd_word        = mem_q[rd_addr];
    assign unused_rd_bits = ^{rd_word[8:7], rd_word[0]};

    always_comb begin
        color_d = 8'h00;
        if (s1_in_maze_q) begin
            if (rd_word[1])      color_d = 8'hF0;
            else if (rd_word[2]) color_d = 8'hFF;
            else                 color_d = 8'h49;

            // Only the first matching edge region is considered, even near corners.
            if (s1_ox_q < 10'(WALL_PX)) begin
                if (rd_word[6]) color_d = 8'hA0;
            end else if (s1_ox_q >= 10'(TILE_SIZE - WALL_PX)) begin
                if (rd_word[4]) color_d = 8'hA0;
            end else if (s1_oy_q < 10'(WALL_PX)) begin
                if (rd_word[5]) color_d = 8'hA0;
            end else if (s1_oy_q >= 10'(TILE_SIZE - WALL_PX)) begin
                if (rd_word[3]) color_d = 8'hA0;
            end

            if (s1_ox_q >= 10'(IR_BUF) && s1_ox_q < 10'(TILE_SIZE - IR_BUF) &&
                s1_oy_q >= 10'(IR_BUF) && s1_oy_q < 10'(TILE_SIZE - IR_BUF)) begin
                case (rd_word[10:9])
                    2'b01:   color_d = 8'hE0;
                    2'b10:   color_d = 8'h1C;
                    2'b11:   color_d = 8'h03;
                    default: ;
                endcase
            end
        end
        if (done_q && s1_banner_q) color_d = 8'h18;
    end

    always_ff @(posedge CLK) begin
        if (!RESET_N) color_q <= 8'h00;
        else          color_q <= color_d;
    end

    assign COLOR_OUT = color_q;

endmodule

// File: tb/tb_maze_mapper_pipe.sv
// -----------------------------------------------------------------------------
// tb_maze_mapper_pipe
//   Scoreboard bench for maze_mapper_pipe. Stimulus tasks push expected
//   observations (value + cycle at which it must be visible) into a queue;
//   a monitor process samples the DUT 1 time unit after every rising edge
//   and compares each entry that falls due. Expected values come from a
//   tile-map model written directly from the behavioural rules.
// -----------------------------------------------------------------------------
module tb_maze_mapper_pipe;
    localparam int MX = 4, MY = 5, T = 70, W = 3, IRB = 20;
    localparam int N_TILES = MX * MY;

    logic        CLK, RESET_N;
    logic [15:0] DATA_IN;
    logic        DATA_VAL, DATA_RDY;
    logic [9:0]  PIXEL_X, PIXEL_Y;
    logic [7:0]  COLOR_OUT, ERR_CNT;
    logic        DONE;

    maze_mapper_pipe dut (
        .CLK       (CLK),
        .RESET_N   (RESET_N),
        .DATA_IN   (DATA_IN),
        .DATA_VAL  (DATA_VAL),
        .DATA_RDY  (DATA_RDY),
        .PIXEL_X   (PIXEL_X),
        .PIXEL_Y   (PIXEL_Y),
        .COLOR_OUT (COLOR_OUT),
        .DONE      (DONE),
        .ERR_CNT   (ERR_CNT)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    typedef enum {K_COLOR, K_RDY, K_DONE, K_ERR} kind_e;
    typedef struct {
        kind_e kind;
        int    due;
        int    exp;
        string name;
    } item_t;

    item_t sb_q[$];
    int    cyc    = 0;
    int    checks = 0;
    int    errors = 0;

    // Reference model state.
    int m_map [N_TILES];
    int m_done, m_err, m_cur_valid, m_cx, m_cy;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic expect_at(input kind_e k, input int due, input int exp, input string name);
        item_t it;
        it.kind = k;
        it.due  = due;
        it.exp  = exp;
        it.name = name;
        sb_q.push_back(it);
    endtask

    // Monitor: runs once per cycle, away from the active edge.
    initial begin
        logic [31:0] act;
        forever begin
            @(posedge CLK);
            #1;
            cyc++;
            for (int i = sb_q.size() - 1; i >= 0; i--) begin
                if (sb_q[i].due <= cyc) begin
                    case (sb_q[i].kind)
                        K_COLOR: act = {24'b0, COLOR_OUT};
                        K_RDY:   act = {31'b0, DATA_RDY};
                        K_DONE:  act = {31'b0, DONE};
                        default: act = {24'b0, ERR_CNT};
                    endcase
                    if (sb_q[i].due < cyc) check({sb_q[i].name, "_late"}, 32'(sb_q[i].due), 32'(cyc));
                    else                   check(sb_q[i].name, act, 32'(sb_q[i].exp));
                    sb_q.delete(i);
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
        $fatal(1, "watchdog");
    end

    // --------------------------------------------------------------- model
    function automatic void model_reset();
        for (int i = 0; i < N_TILES; i++) m_map[i] = 0;
        m_done = 0; m_err = 0; m_cur_valid = 0; m_cx = 0; m_cy = 0;
    endfunction

    // Applies one accepted update; returns 1 when an old current tile gets cleared.
    function automatic int model_update(input logic [15:0] w);
        int x, y, p, clr;
        x = int'(w[15:14]);
        y = int'(w[13:11]);
        p = int'(w[10:0]);
        clr = 0;
        if (x >= MX || y >= MY) begin
            if (m_err < 255) m_err++;
            return 0;
        end
        m_map[y*MX + x] = p;
        if (p & 1) m_done = 1;
        if (p & 2) begin
            if (m_cur_valid != 0 && (x != m_cx || y != m_cy)) begin
                clr = 1;
                m_map[m_cy*MX + m_cx] = m_map[m_cy*MX + m_cx] & ~2;
            end
            m_cx = x; m_cy = y; m_cur_valid = 1;
        end else if (x == m_cx && y == m_cy) begin
            m_cur_valid = 0;
        end
        return clr;
    endfunction

    function automatic int model_color(input int x, input int y);
        int py, tx, ty, ox, oy, w, c, tr;
        py = (479 - y) & 1023;
        c  = 0;
        if (x < MX*T && py < MY*T) begin
            tx = x / T;  ty = py / T;
            ox = x % T;  oy = py % T;
            w  = m_map[ty*MX + tx];
            if (w & 'h2)      c = 'hF0;
            else if (w & 'h4) c = 'hFF;
            else              c = 'h49;
            if (ox < W)            begin if (w & 'h40) c = 'hA0; end
            else if (ox >= T - W)  begin if (w & 'h10) c = 'hA0; end
            else if (oy < W)       begin if (w & 'h20) c = 'hA0; end
            else if (oy >= T - W)  begin if (w & 'h08) c = 'hA0; end
            tr = (w >> 9) & 3;
            if (ox >= IRB && ox < T - IRB && oy >= IRB && oy < T - IRB && tr != 0)
                c = (tr == 1) ? 'hE0 : (tr == 2) ? 'h1C : 'h03;
        end
        if (m_done != 0 && x >= 500 && x <= 550) c = 'h18;
        return c;
    endfunction

    // ----------------------------------------------------------- stimulus
    task automatic idle(input int n);
        repeat (n) @(negedge CLK);
    endtask

    // want < 0 takes the expected colour from the model.
    task automatic pix(input int x, input int y, input int want, input string name);
        @(negedge CLK);
        PIXEL_X = 10'(x);
        PIXEL_Y = 10'(y);
        expect_at(K_COLOR, cyc + 2, (want < 0) ? model_color(x, y) : want, name);
    endtask

    task automatic send(input logic [15:0] w);
        int n;
        int clr;
        @(negedge CLK);
        DATA_IN  = w;
        DATA_VAL = 1'b1;
        n = 0;
        while (DATA_RDY !== 1'b1 && n < 50) begin
            @(negedge CLK);
            n++;
        end
        if (DATA_RDY !== 1'b1) begin
            check("send_rdy_timeout", {31'b0, DATA_RDY}, 32'd1);
            DATA_VAL = 1'b0;
            return;
        end
        // Transfer happens at the next rising edge (cycle cyc+1).
        clr = model_update(w);
        expect_at(K_ERR,  cyc + 1, m_err,  "err_cnt");
        expect_at(K_DONE, cyc + 1, m_done, "done");
        if (clr != 0) begin
            expect_at(K_RDY, cyc + 1, 0, "clr_rdy_low");
            expect_at(K_RDY, cyc + 2, 1, "clr_rdy_high");
        end else begin
            expect_at(K_RDY, cyc + 1, 1, "rdy_after_xfer");
        end
        @(negedge CLK);
        DATA_VAL = 1'b0;
    endtask

    task automatic do_reset(input int hold);
        @(negedge CLK);
        RESET_N  = 1'b0;
        DATA_VAL = 1'b0;
        repeat (hold) @(negedge CLK);
        RESET_N = 1'b1;
        model_reset();
        for (int k = 1; k < N_TILES; k++) expect_at(K_RDY, cyc + k, 0, "init_rdy_low");
        expect_at(K_RDY,   cyc + N_TILES, 1, "init_rdy_high");
        expect_at(K_DONE,  cyc + 1, 0, "rst_done");
        expect_at(K_ERR,   cyc + 1, 0, "rst_err");
        expect_at(K_COLOR, cyc + 1, 0, "rst_color");
        repeat (N_TILES + 1) @(negedge CLK);
    endtask

    task automatic scan_clear();
        for (int ty = 0; ty < MY; ty++)
            for (int tx = 0; tx < MX; tx++) begin
                pix(tx*T + 35, 479 - (ty*T + 35), 'h49, "clear_center");
                pix(tx*T + 1,  479 - (ty*T + 35), 'h49, "clear_edge");
            end
        pix(520, 100, 'h00, "banner_off");
    endtask

    function automatic logic [15:0] rand_word();
        logic [1:0]  x;
        logic [2:0]  y;
        logic [10:0] p;
        x = 2'($urandom % 4);
        y = 3'($urandom_range(0, 5));
        p = 11'($urandom);
        p[0] = ($urandom % 16 == 0);
        return {x, y, p};
    endfunction

    initial begin
        RESET_N  = 1'b0;
        DATA_IN  = '0;
        DATA_VAL = 1'b0;
        PIXEL_X  = '0;
        PIXEL_Y  = '0;
        model_reset();

        do_reset(3);
        scan_clear();
        idle(2);

        // Explored tile (1,2) with a left wall.
        send(16'h5044);
        pix(71,  300, 'hA0, "left_wall");
        pix(105, 300, 'hFF, "explored");
        idle(2);

        // Current moves from (0,0) to (3,4): old flag is cleared.
        send(16'h0002);
        send(16'hE002);
        pix(220, 189, 'hF0, "current_tile");
        pix(35,  444, 'h49, "old_current_cleared");
        idle(2);

        // Out-of-range y: rejected, counted, saturating.
        send(16'hE800);
        for (int i = 0; i < 255; i++) send(16'hE800);
        pix(105, 300, 'hFF, "map_unchanged");
        idle(2);

        // Sticky done and the banner.
        send(16'h0001);
        send(16'h0000);
        pix(520, 100, 'h18, "banner_on");
        pix(551, 100, 'h00, "banner_edge_off");
        pix(500, 100, 'h18, "banner_left_edge");
        idle(2);

        // Randomized updates interleaved with randomized pixel reads.
        for (int r = 0; r < 12; r++) begin
            for (int u = 0; u < 15; u++) send(rand_word());
            for (int p = 0; p < 25; p++)
                pix($urandom_range(0, 639), $urandom_range(0, 479), -1, "rand_pix");
            idle(2);
        end

        // Reset pulse mid-sweep at address 7: sweep restarts from zero.
        @(negedge CLK);
        RESET_N = 1'b0;
        @(negedge CLK);
        RESET_N = 1'b1;
        model_reset();
        repeat (6) @(negedge CLK);
        do_reset(1);
        scan_clear();

        idle(6);
        check("sb_drain", 32'(sb_q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
